// File: rtl/switch_egress_port_pkg.sv
// Shared types for the switch egress port: axis_d requester/sink beats, egress beat, FSM states.
// No logic; FLUSH state exists only when EGRESS_WATCHDOG_EN is defined.
// Backpressure is carried by axis_d_sink_t.tready and the egress_ready input.
package switch_egress_port_pkg;

   localparam int DATA_W            = 32;
   localparam int DEST_W            = 4;
   localparam int DEFAULT_NUM_PORTS = 4;
   localparam int DEFAULT_PORT_ID   = 0;

   typedef struct packed {
      logic              tvalid;
      logic [DATA_W-1:0] tdata;
      logic              tlast;
      logic [DEST_W-1:0] tdest;
   } axis_d_source_t;

   typedef struct packed {
      logic tready;
   } axis_d_sink_t;

   typedef struct packed {
      logic              tvalid;
      logic [DATA_W-1:0] tdata;
      logic              tlast;
   } axis_source_t;

`ifdef EGRESS_WATCHDOG_EN
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_FLUSH} egress_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT} egress_state_t;
`endif

endpackage

// File: rtl/egress_skid_buffer.sv
// Two-entry register slice between the arbiter and the egress MAC.
// Latency: one cycle in to out; full throughput while out_ready stays high.
// Backpressure: in_ready is registered and drops the cycle after a beat lands in the skid slot.
module egress_skid_buffer
   import switch_egress_port_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  axis_source_t in_pkt,
   output logic         in_ready,
   output axis_source_t out_pkt,
   input  logic         out_ready
);

   axis_source_t out_q;
   axis_source_t skid_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else if (out_ready || !out_q.tvalid) begin
         // Output slot frees up: drain the skid slot first so ordering holds.
         if (skid_q.tvalid) begin
            out_q  <= skid_q;
            skid_q <= '0;
         end else begin
            out_q <= in_pkt;
         end
      end else if (in_pkt.tvalid && !skid_q.tvalid) begin
         skid_q <= in_pkt;
      end
   end

   assign in_ready = !skid_q.tvalid;
   assign out_pkt  = out_q;

endmodule

// File: rtl/switch_egress_port.sv
// Round-robin egress arbiter: grants one axis_d requester per frame and forwards it to the MAC.
// Latency: grant one cycle after eligibility, data one cycle ingress to egress; EGRESS_WATCHDOG_EN adds stall abort.
// Backpressure: granted tready follows the skid stage in_ready; egress_ready stalls the skid stage.
module switch_egress_port
   import switch_egress_port_pkg::*;
#(
   parameter int  NUM_PORTS       = DEFAULT_NUM_PORTS,
   parameter int  PORT_ID         = DEFAULT_PORT_ID,
   parameter int  WATCHDOG_CYCLES = 16,
   parameter int  FRAME_CTR_WIDTH = 16,
   localparam int IDX_W           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  axis_d_source_t [NUM_PORTS-1:0]      ingress_source,
   output axis_d_sink_t   [NUM_PORTS-1:0]      ingress_sink,
   output axis_source_t                        egress_pkt,
   input  logic                                egress_ready,
   output logic                                busy,
   output logic [IDX_W-1:0]                    grant_id,
   output logic [FRAME_CTR_WIDTH-1:0]          frame_count,
   output logic                                abort_pulse
);

   egress_state_t              state;
   logic [IDX_W-1:0]           grant_q;
   logic [IDX_W-1:0]           rr_ptr;
   logic [IDX_W-1:0]           next_ptr;
   logic                       mid_frame;
   logic [NUM_PORTS-1:0]       eligible;
   logic                       arb_found;
   logic [IDX_W-1:0]           arb_idx;
   logic                       cur_vld;
   logic [DATA_W-1:0]          cur_dat;
   logic                       cur_last;
   logic                       xfer;
   axis_source_t               skid_in;
   logic                       skid_in_ready;
   logic [FRAME_CTR_WIDTH-1:0] frame_q;

`ifdef EGRESS_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
   logic [WD_W-1:0] wd_cnt;
   logic            abort_q;
   assign abort_pulse = abort_q;
`else
   localparam int unused_wd_cycles = WATCHDOG_CYCLES;
   assign abort_pulse = 1'b0;
`endif

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         eligible[i] = ingress_source[i].tvalid && (ingress_source[i].tdest == DEST_W'(PORT_ID));
   end

   // First eligible index at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_PORTS;
         if (!arb_found && eligible[idx]) begin
            arb_found = 1'b1;
            arb_idx   = IDX_W'(idx);
         end
      end
   end

   assign next_ptr = IDX_W'((int'(grant_q) + 1) % NUM_PORTS);
   assign cur_vld  = ingress_source[grant_q].tvalid;
   assign cur_dat  = ingress_source[grant_q].tdata;
   assign cur_last = ingress_source[grant_q].tlast;
   assign xfer     = (state == ST_GRANT) && cur_vld && skid_in_ready;

   always_comb begin
      skid_in = '0;
      if (state == ST_GRANT) begin
         skid_in.tvalid = cur_vld;
         skid_in.tdata  = cur_dat;
         skid_in.tlast  = cur_last;
      end
`ifdef EGRESS_WATCHDOG_EN
      else if (state == ST_FLUSH) begin
         skid_in.tvalid = 1'b1;
         skid_in.tlast  = 1'b1;
      end
`endif
   end

   always_comb begin
      ingress_sink = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (state == ST_GRANT && grant_q == IDX_W'(i))
            ingress_sink[i].tready = skid_in_ready;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr    <= '0;
         mid_frame <= 1'b0;
`ifdef EGRESS_WATCHDOG_EN
         wd_cnt    <= '0;
         abort_q   <= 1'b0;
`endif
      end else begin
`ifdef EGRESS_WATCHDOG_EN
         abort_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  grant_q   <= arb_idx;
                  state     <= ST_GRANT;
                  mid_frame <= 1'b0;
`ifdef EGRESS_WATCHDOG_EN
                  wd_cnt    <= '0;
`endif
               end
            end
            ST_GRANT: begin
               if (xfer) begin
                  mid_frame <= !cur_last;
`ifdef EGRESS_WATCHDOG_EN
                  wd_cnt    <= '0;
`endif
                  if (cur_last) begin
                     state  <= ST_IDLE;
                     rr_ptr <= next_ptr;
                  end
               end else if (!cur_vld) begin
                  // A requester that withdrew before its first beat loses the grant.
                  if (!mid_frame)
                     state <= ST_IDLE;
`ifdef EGRESS_WATCHDOG_EN
                  else if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
                     state   <= ST_FLUSH;
                     abort_q <= 1'b1;
                     rr_ptr  <= next_ptr;
                  end else
                     wd_cnt <= wd_cnt + WD_W'(1);
`endif
               end
            end
`ifdef EGRESS_WATCHDOG_EN
            ST_FLUSH: begin
               if (skid_in_ready)
                  state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         frame_q <= '0;
      else if (egress_pkt.tvalid && egress_ready && egress_pkt.tlast && frame_q != '1)
         frame_q <= frame_q + FRAME_CTR_WIDTH'(1);
   end

   egress_skid_buffer u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_pkt    (skid_in),
      .in_ready  (skid_in_ready),
      .out_pkt   (egress_pkt),
      .out_ready (egress_ready)
   );

   assign busy        = (state != ST_IDLE);
   assign grant_id    = grant_q;
   assign frame_count = frame_q;

endmodule
